z80_bus_master: RTL and testbench
=================================

Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, one Z80 T-state per clk cycle.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req_valid  in  1  bus-cycle request; req_ready  out  1  accept strobe.
REQ-004 SHALL have ports: req_op  in  3  cycle type: 000 mem read, 001 mem write, 010 io read, 011 io write, 100 M1 opcode fetch; 101-111 reserved.
REQ-005 SHALL have ports: req_addr  in  16  address; req_wdata  in  8  write data.
REQ-006 SHALL have ports: rsp_valid  out  1  completion pulse; rsp_data  out  8  read/fetch data.
REQ-007 SHALL have ports: addr  out  16; data_out  out  8; data_oe  out  1; data_in  in  8.
REQ-008 SHALL have ports: mreq_n, iorq_n, rd_n, wr_n, m1_n, refresh_n  out  1 each, all active-low; wait_n  in  1  active-low wait.

Function
REQ-009 SHALL implement states IDLE, T1, T2, TW, T3, T4; req_ready = 1 only in IDLE.
REQ-010 SHALL accept a request when req_valid && req_ready, latch op/addr/wdata, and enter T1 on the next clock.
REQ-011 Reserved req_op values SHALL be accepted and completed as a 3-state cycle with all strobes high, rsp_data = 8'hFF.
REQ-012 Mem read: mreq_n=0 and rd_n=0 in T1, T2, TW, T3.
REQ-013 Mem write: mreq_n=0 in T1-T3; data_oe=1 with data_out=wdata in T1-T3; wr_n=0 in T2, TW, T3 only.
REQ-014 IO read/write: iorq_n=0 plus rd_n=0 (read) or wr_n=0 (write) in T2, TW, T3; T1 drives address only; one TW is always inserted.
REQ-015 M1 fetch: m1_n=0, mreq_n=0, rd_n=0 in T1, T2, TW; T3 and T4 form the refresh phase per REQ-027.
REQ-016 addr SHALL equal the latched address in T1 through the end of the read/write phase; it is 16'h0000 in IDLE.
REQ-017 wait_n SHALL be sampled at the end of T2 (and of each TW): if 0, next state is TW; if 1, next state is T3; wait_n is ignored in all other states.
REQ-018 Read data SHALL be captured from data_in on the clock edge leaving the last T2/TW (M1) or leaving T3 (mem/io read).
REQ-019 Non-M1 cycles SHALL return from T3 to IDLE; M1 SHALL go T3 -> T4 -> IDLE.
REQ-020 rsp_valid SHALL pulse for exactly one clock on the first IDLE clock after a cycle; rsp_data holds the captured byte until the next read completes, writes leave it unchanged.
REQ-021 Minimum latency accept -> rsp_valid: mem 4 clocks, io 5 clocks, M1 5 clocks; each wait clock adds one.
REQ-022 No two strobes of different type (mreq_n/iorq_n) SHALL be low in the same clock; rd_n and wr_n SHALL never both be low.
REQ-023 A request presented while not IDLE SHALL not be accepted and SHALL not disturb the active cycle.

Reset
REQ-024 When reset=1 on a clock edge, next state SHALL be IDLE from any state, including mid-cycle with wait_n low.
REQ-025 Reset values: all active-low strobes 1, data_oe 0, addr 16'h0000, data_out 8'h00, rsp_valid 0, rsp_data 8'h00, refresh counter 7'h00; req_ready 1 from the first clock after reset.
REQ-026 An aborted cycle SHALL produce no rsp_valid.

Configuration
REQ-027 With Z80_BUS_MASTER_REFRESH_EN defined: in M1 T3/T4, m1_n=1, rd_n=1, refresh_n=0, mreq_n=0 in T3 only, addr={9'b0, r[6:0]}, 7-bit r increments (wrapping 7'h7F -> 7'h00) on leaving T4.
REQ-028 Without Z80_BUS_MASTER_REFRESH_EN: refresh_n constantly 1, r absent, M1 T3/T4 drive all strobes high and addr 16'h0000; timing is otherwise identical.

Verification
REQ-029 Mem read 16'h1234, wait_n=1, data_in=8'hA5 -> mreq_n/rd_n low 3 clocks, rsp_valid 4 clocks after accept, rsp_data=8'hA5.
REQ-030 IO write addr 16'h00C0 wdata 8'h5A, wait_n low 2 clocks -> iorq_n/wr_n low in T2, 3xTW, T3; data_oe 5 clocks; rsp_valid at clock 7.
REQ-031 130 back-to-back M1 fetches (REFRESH_EN) -> refresh_n low 2 clocks each; refresh addr sequence 0..127, 0, 1; opcode captured before T3.
REQ-032 Reset asserted in TW of a mem write with wait_n=0 -> next clock all strobes high, data_oe 0, IDLE, no rsp_valid.
REQ-033 req_valid held high during an active cycle and req_op=3'b111 -> second request accepted only in IDLE; reserved op gives no strobes, rsp_data=8'hFF.

Source files
------------

// File: rtl/z80_bus_master.sv
// z80_bus_master: drives one Z80 machine cycle per accepted request.
// The cycle types are memory read/write, IO read/write and M1 opcode fetch.
// The bus runs at one T-state per clk cycle.
// Optional feature macro: Z80_BUS_MASTER_REFRESH_EN enables the DRAM refresh
// phase (refresh_n, 7-bit R counter) during M1 T3/T4.
//
// Request handshake: a request is taken on a rising clk edge where
// req_valid && req_ready. req_ready is high only while the FSM is IDLE.
// req_op/req_addr/req_wdata are captured on that edge. Nothing is taken
// while a cycle is active. rsp_valid is a one-clock pulse with no
// back-pressure; it is raised on the first IDLE clock after a completed cycle.
module z80_bus_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m1_n,
    output logic        refresh_n,
    input  logic        wait_n,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    localparam logic [2:0] OP_MEM_RD = 3'b000;
    localparam logic [2:0] OP_MEM_WR = 3'b001;
    localparam logic [2:0] OP_IO_RD  = 3'b010;
    localparam logic [2:0] OP_IO_WR  = 3'b011;
    localparam logic [2:0] OP_M1     = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        rsp_valid_q;

    logic accept;
    logic is_mem, is_io, is_m1, is_rsvd, is_wr;
    logic capture_m1, capture_rd;

`ifdef Z80_BUS_MASTER_REFRESH_EN
    logic [6:0] r_q;
`endif

    assign accept  = (state_q == S_IDLE) && req_valid;
    assign is_mem  = (op_q == OP_MEM_RD) || (op_q == OP_MEM_WR);
    assign is_io   = (op_q == OP_IO_RD) || (op_q == OP_IO_WR);
    assign is_m1   = (op_q == OP_M1);
    assign is_rsvd = (op_q > OP_M1);
    // Bit 0 distinguishes write from read for both memory and IO ops.
    assign is_wr   = op_q[0];

    // M1 samples the opcode as the bus leaves the last T2/TW; plain reads
    // sample at the end of T3.
    assign capture_m1 = is_m1 && ((state_q == S_T2) || (state_q == S_TW)) && (state_d == S_T3);
    assign capture_rd = (is_mem || is_io) && !is_wr && (state_q == S_T3);

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rdata_q;
    assign dbg_state_o = state_q;

    // State register, request latch, read-data capture and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            rsp_valid_q <= ((state_q == S_T3) && !is_m1) || (state_q == S_T4);
            if (capture_m1 || capture_rd) begin
                rdata_q <= data_in;
            end else if ((state_q == S_T3) && is_rsvd) begin
                rdata_q <= 8'hFF;
            end
        end
    end

`ifdef Z80_BUS_MASTER_REFRESH_EN
    // Refresh row counter; advances once per completed M1 as it leaves T4.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 7'h00;
        end else if (state_q == S_T4) begin
            r_q <= r_q + 7'h01;
        end
    end
`endif

    // Next-state logic and bus pin decode from the current T-state and op.
    always_comb begin
        state_d   = state_q;
        addr      = 16'h0000;
        data_out  = 8'h00;
        data_oe   = 1'b0;
        mreq_n    = 1'b1;
        iorq_n    = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        m1_n      = 1'b1;
        refresh_n = 1'b1;

        case (state_q)
            S_IDLE: if (req_valid) state_d = S_T1;
            S_T1:   state_d = S_T2;
            // Reserved ops never wait; IO always gets one TW before wait_n matters.
            S_T2: begin
                if (is_rsvd)      state_d = S_T3;
                else if (is_io)   state_d = S_TW;
                else if (!wait_n) state_d = S_TW;
                else              state_d = S_T3;
            end
            S_TW:   state_d = wait_n ? S_T3 : S_TW;
            S_T3:   state_d = is_m1 ? S_T4 : S_IDLE;
            S_T4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (is_mem && (state_q != S_T4)) begin
                addr   = addr_q;
                mreq_n = 1'b0;
                if (is_wr) begin
                    data_oe  = 1'b1;
                    data_out = wdata_q;
                    wr_n     = (state_q == S_T1);
                end else begin
                    rd_n = 1'b0;
                end
            end else if (is_io && (state_q != S_T4)) begin
                addr = addr_q;
                if (state_q != S_T1) begin
                    iorq_n = 1'b0;
                    if (is_wr) begin
                        wr_n     = 1'b0;
                        data_oe  = 1'b1;
                        data_out = wdata_q;
                    end else begin
                        rd_n = 1'b0;
                    end
                end
            end else if (is_m1) begin
                if ((state_q == S_T1) || (state_q == S_T2) || (state_q == S_TW)) begin
                    addr   = addr_q;
                    m1_n   = 1'b0;
                    mreq_n = 1'b0;
                    rd_n   = 1'b0;
                end else begin
`ifdef Z80_BUS_MASTER_REFRESH_EN
                    addr      = {9'b0, r_q};
                    refresh_n = 1'b0;
                    mreq_n    = (state_q != S_T3);
`else
                    addr = 16'h0000;
`endif
                end
            end else if (is_rsvd && (state_q != S_T4)) begin
                addr = addr_q;
            end
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Self-checking bench for z80_bus_master: randomized bus cycles, per-clock pin
// checks against a table of expected pin levels per cycle type and T-state,
// and a response scoreboard (data + completion clock) drained by a monitor.
`timescale 1ns/1ps
module tb_z80_bus_master;

    localparam int PH_IDLE = 0;
    localparam int PH_T1   = 1;
    localparam int PH_T2   = 2;
    localparam int PH_TW   = 3;
    localparam int PH_T3   = 4;
    localparam int PH_T4   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, refresh_n;
    logic        wait_n;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [7:0] last_rd = 8'h00;
    logic [6:0] r_model = 7'h00;

    z80_bus_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .refresh_n(refresh_n), .wait_n(wait_n),
        .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pins_now();
        return {addr, data_out, data_oe, mreq_n, iorq_n, rd_n, wr_n, m1_n, refresh_n, req_ready};
    endfunction

    // Expected pin levels for a cycle type in a given T-state, straight from the
    // bus timing table. Packing matches pins_now().
    function automatic logic [31:0] exp_pins(input int op, input int ph,
                                             input logic [15:0] a, input logic [7:0] wd);
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        logic        e_oe, e_mreq, e_iorq, e_rd, e_wr, e_m1, e_rf, e_rdy;
        e_addr = 16'h0000; e_dout = 8'h00; e_oe = 1'b0;
        e_mreq = 1'b1; e_iorq = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_m1 = 1'b1; e_rf = 1'b1;
        e_rdy  = (ph == PH_IDLE);
        if (ph != PH_IDLE) begin
            case (op)
                0: begin e_addr = a; e_mreq = 1'b0; e_rd = 1'b0; end
                1: begin
                    e_addr = a; e_mreq = 1'b0; e_oe = 1'b1; e_dout = wd;
                    e_wr = (ph == PH_T1);
                end
                2, 3: begin
                    e_addr = a;
                    if (ph != PH_T1) begin
                        e_iorq = 1'b0;
                        if (op == 2) e_rd = 1'b0;
                        else begin e_wr = 1'b0; e_oe = 1'b1; e_dout = wd; end
                    end
                end
                4: begin
                    if (ph == PH_T1 || ph == PH_T2 || ph == PH_TW) begin
                        e_addr = a; e_m1 = 1'b0; e_mreq = 1'b0; e_rd = 1'b0;
                    end else begin
`ifdef Z80_BUS_MASTER_REFRESH_EN
                        e_addr = {9'b0, r_model};
                        e_rf   = 1'b0;
                        e_mreq = (ph == PH_T4);
`endif
                    end
                end
                default: e_addr = a;
            endcase
        end
        return {e_addr, e_dout, e_oe, e_mreq, e_iorq, e_rd, e_wr, e_m1, e_rf, e_rdy};
    endfunction

    // Issue one bus cycle with w wait clocks (for IO: total TW count, >= 1).
    // fixed_din >= 0 forces data_in, otherwise data_in is random each clock.
    task automatic run_txn(input int op, input logic [15:0] a, input logic [7:0] wd,
                           input int w, input int fixed_din);
        logic [7:0] dv[16];
        logic [7:0] exp_d;
        int n, acc, ph;
        for (int c = 0; c < 16; c++) dv[c] = (fixed_din >= 0) ? 8'(fixed_din) : 8'($urandom);
        n = (op == 4) ? 4 + w : 3 + w;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'(op); req_addr = a; req_wdata = wd;
        wait_n = 1'($urandom); data_in = 8'($urandom);
        chk("idle_pins", pins_now(), exp_pins(op, PH_IDLE, a, wd));
        acc = cyc;
        if (op == 4)                exp_d = dv[2 + w];
        else if (op == 0 || op == 2) exp_d = dv[3 + w];
        else if (op > 4)            exp_d = 8'hFF;
        else                        exp_d = last_rd;
        if (op != 1 && op != 3) last_rd = exp_d;
        exp_q.push_back(exp_d);
        exp_cyc_q.push_back(acc + n + 1);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            // Keep a competing request pending while busy; it must be ignored.
            req_valid = (c != n); req_op = 3'($urandom_range(0, 7));
            req_addr = 16'($urandom); req_wdata = 8'($urandom);
            data_in = dv[c];
            wait_n = 1'($urandom);
            if ((op <= 1 || op == 4) && c >= 2 && c <= 2 + w) wait_n = (c == 2 + w);
            if ((op == 2 || op == 3) && c >= 3 && c <= 2 + w) wait_n = (c == 2 + w);
            if (c == 1) ph = PH_T1;
            else if (c == 2) ph = PH_T2;
            else if (c <= 2 + w) ph = PH_TW;
            else if (c == 3 + w) ph = PH_T3;
            else ph = PH_T4;
            chk($sformatf("bus_op%0d_c%0d", op, c), pins_now(), exp_pins(op, ph, a, wd));
        end
        if (op == 4) r_model = r_model + 7'h01;
    endtask

    // Mem write aborted by reset while stretched in TW with wait_n low.
    task automatic abort_write();
        logic [15:0] a;
        logic [7:0]  wd;
        a = 16'($urandom); wd = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_addr = a; req_wdata = wd; wait_n = 1'b1;
        chk("abort_idle", pins_now(), exp_pins(1, PH_IDLE, a, wd));
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_t1", pins_now(), exp_pins(1, PH_T1, a, wd));
        @(negedge clk);
        wait_n = 1'b0;
        chk("abort_t2", pins_now(), exp_pins(1, PH_T2, a, wd));
        @(negedge clk);
        chk("abort_tw", pins_now(), exp_pins(1, PH_TW, a, wd));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rd = 8'h00; r_model = 7'h00;
        chk("abort_pins", pins_now(), exp_pins(1, PH_IDLE, a, wd));
        chk("abort_rsp_data", rsp_data, last_rd);
        repeat (4) begin
            @(negedge clk);
            chk("abort_hold", pins_now(), exp_pins(1, PH_IDLE, a, wd));
        end
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            chk("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
                chk("rsp_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int op, w;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0; req_wdata = 8'h0;
        data_in = 8'h00; wait_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pins", pins_now(), exp_pins(0, PH_IDLE, 16'h0, 8'h0));
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 8'h00);
        reset = 1'b0;

        run_txn(0, 16'h1234, 8'h00, 0, 8'hA5);
        run_txn(3, 16'h00C0, 8'h5A, 3, -1);
        run_txn(0, 16'($urandom), 8'h00, 1, -1);
        run_txn(7, 16'($urandom), 8'h00, 0, -1);
        run_txn(1, 16'($urandom), 8'($urandom), 2, -1);

        abort_write();

        for (int i = 0; i < 130; i++) run_txn(4, 16'($urandom), 8'h00, $urandom_range(0, 2), -1);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 7);
            if (op <= 1 || op == 4) w = $urandom_range(0, 3);
            else if (op <= 3)       w = $urandom_range(1, 4);
            else                    w = 0;
            run_txn(op, 16'($urandom), 8'($urandom), w, -1);
        end

        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
